alu_seq_unit: RTL and testbench
===============================

// Module: alu_seq_unit
// PURPOSE
//   Sequential, handshaked ALU responder. Accepts one {a,b,op} request over valid/ready and
//   returns a registered {result,sign,overflow,status} response over valid/ready.
//   Op encoding and results match the combinational ALU. SQUARE and RIGHT SHIFT are iterative.
//   Sits between a command source (sequencer/CPU bus) and result consumers. One request in flight.
// PARAMETERS
//   N     5   operand/result width, two's complement, N>=3
// PORTS
//   clk        in   1   single clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   request valid
//   in_ready   out  1   request accepted when in_valid&&in_ready at clk edge
//   a          in   N   operand A, signed
//   b          in   N   operand B, signed (shift amount as unsigned for op 111)
//   op         in   3   000 ADD,001 SUB,010 MAX,011 A<=B,100 AVG,101 SQUARE,110 ABS,111 ASR
//   out_valid  out  1   response valid
//   out_ready  in   1   response consumed when out_valid&&out_ready at clk edge
//   result     out  N   registered result
//   sign       out  1   result[N-1]; forced 0 for op 011
//   overflow   out  1   signed overflow (ADD/SUB/SQUARE/ABS), else 0
//   status     out  1   compare outcome for op 011, else 0
// BEHAVIOUR
//   Reset (rst_n low, async): state=IDLE; out_valid=0; result/sign/overflow/status=0;
//     in_ready=0 while rst_n low; iteration counter and operand registers cleared.
//   FSM: IDLE -> (accept) EXEC or DONE; EXEC -> DONE when counter hits 0; DONE -> IDLE on out handshake.
//   in_ready=1 only in IDLE. No overlap: one idle bubble after each response handshake
//     (accept never occurs in the same cycle as out handshake).
//   Single-cycle ops (000,001,010,011,100,110, and 111 with shamt 0): IDLE -> DONE;
//     out_valid rises 1 cycle after the accept edge.
//   SQUARE: |a| held in N+1 bits (handles -2^(N-1)); shift-add, one bit per cycle, N EXEC cycles;
//     out_valid 1+N cycles after accept. result = product[N-1:0];
//     overflow=1 if product > 2^(N-1)-1.
//   ASR: shamt = min(b as unsigned, N-1); one arithmetic shift per EXEC cycle;
//     latency 1+shamt. Sign bit replicated.
//   ADD/SUB: N-bit wrap; overflow = operand signs equal (B inverted for SUB) and result sign differs.
//   MAX: signed max. A<=B: signed compare, result=1 or 0 zero-extended, status=same bit.
//   AVG: (a+b) in N+1 bits, arithmetic >>1 (floor toward -inf); never overflows.
//   ABS: -a if a<0; a=-2^(N-1) returns -2^(N-1) with overflow=1.
//   DONE: result/flags/out_valid held stable while out_ready=0; in_valid ignored.
//   Inputs a,b,op sampled only at the accept edge; later changes have no effect.
//   Reset mid-operation aborts silently: no response is produced for the aborted request.
// TESTING
//   ADD a=11011 b=00011 -> result 11110, sign1, ovf0; out_valid exactly 1 cycle after accept.
//   ADD 01111+00001 -> 10000, sign1, ovf1. SUB 00111-00011 -> 00100, ovf0.
//     ABS 10000 -> 10000, ovf1.
//   CMP 11100<=00001 -> result 00001, status1, sign0. AVG 11100,00010 -> 11111.
//     MAX 11101,00010 -> 00010.
//   SQUARE a=11101 -> 01001, ovf0, latency 6 (N=5). SQUARE a=00110 -> 00100, ovf1.
//     SQUARE a=10000 -> 00000, ovf1.
//   ASR 11100 by 1 -> 11110, latency 2. ASR 11100 by b=01001 (clamped to 4) -> 11111, latency 5.
//     ASR by 0 -> unchanged, latency 1.
//   Backpressure: hold out_ready=0 for 3 cycles -> outputs stable, in_ready=0,
//     in_valid pulses ignored. Release -> in_ready=1 the next cycle.
//   Reset mid-SQUARE (rst_n low 2 cycles in EXEC) -> out_valid=0, result=0, in_ready=0 during reset.
//     Next request completes correctly.

Source files
------------

// File: rtl/alu_seq_if.sv
// Request/response channel of the sequential ALU: valid/ready request with operands,
// valid/ready response with registered result and flags.
interface alu_seq_if #(parameter int N = 5);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         sign;
  logic         overflow;
  logic         status;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, sign, overflow, status
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, sign, overflow, status
  );
endinterface

// File: rtl/alu_seq_unit.sv
// Handshaked ALU responder, one request in flight. Most ops finish in one cycle;
// SQUARE (shift-add) and ASR (one shift per cycle) iterate in EXEC.
module alu_seq_unit #(
  parameter int N = 5
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0]  CNT_N  = N[CW-1:0];
  localparam logic [CW-1:0]  CNT_1  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]   SH_MAX = N[N-1:0] - 1'b1;
  localparam logic [2*N-1:0] SQ_MAX = {{(N+1){1'b0}}, {(N-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t         state, state_next;
  logic [CW-1:0]  cnt;
  logic [2:0]     op_r;
  logic [2*N-1:0] acc, mcand;
  logic [N:0]     mplier;
  logic [N-1:0]   shreg;

  logic           accept, last, iterative;
  logic [N-1:0]   sum, diff, neg, avg, shamt, sc_res, asr_next;
  logic [N:0]     a_ext, abs_a;
  logic [2*N-1:0] sq_next;
  logic           le, sc_ovf, sc_status;

  assign accept    = bus.in_valid && (state == IDLE);
  assign last      = (cnt == CNT_1);
  assign shamt     = (bus.b >= SH_MAX) ? SH_MAX : bus.b;
  assign iterative = (bus.op == 3'b101) || ((bus.op == 3'b111) && (shamt != '0));
  assign sq_next   = acc + (mplier[0] ? mcand : '0);
  assign asr_next  = $signed(shreg) >>> 1;

  always_comb begin
    sc_res    = bus.a;
    sc_ovf    = 1'b0;
    sc_status = 1'b0;
    sum       = bus.a + bus.b;
    diff      = bus.a - bus.b;
    neg       = -bus.a;
    le        = ($signed(bus.a) <= $signed(bus.b));
    // floor((a+b)/2) without the carry bit: halves summed plus the dropped LSB pair
    avg       = {bus.a[N-1], bus.a[N-1:1]} + {bus.b[N-1], bus.b[N-1:1]}
              + {{(N-1){1'b0}}, bus.a[0] & bus.b[0]};
    a_ext     = {bus.a[N-1], bus.a};
    abs_a     = bus.a[N-1] ? -a_ext : a_ext;
    case (bus.op)
      3'b000: begin
        sc_res = sum;
        sc_ovf = (bus.a[N-1] == bus.b[N-1]) && (sum[N-1] != bus.a[N-1]);
      end
      3'b001: begin
        sc_res = diff;
        sc_ovf = (bus.a[N-1] != bus.b[N-1]) && (diff[N-1] != bus.a[N-1]);
      end
      3'b010: sc_res = ($signed(bus.a) >= $signed(bus.b)) ? bus.a : bus.b;
      3'b011: begin
        sc_res    = {{(N-1){1'b0}}, le};
        sc_status = le;
      end
      3'b100: sc_res = avg;
      3'b110: begin
        sc_res = bus.a[N-1] ? neg : bus.a;
        sc_ovf = (bus.a == {1'b1, {(N-1){1'b0}}});
      end
      default: sc_res = bus.a;
    endcase
  end

  always_comb begin
    state_next    = state;
    bus.in_ready  = rst_n && (state == IDLE);
    bus.out_valid = (state == DONE);
    case (state)
      IDLE: if (accept) state_next = iterative ? EXEC : DONE;
      EXEC: if (last) state_next = DONE;
      DONE: if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      op_r         <= '0;
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      shreg        <= '0;
      bus.result   <= '0;
      bus.sign     <= 1'b0;
      bus.overflow <= 1'b0;
      bus.status   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_r <= bus.op;
          if (bus.op == 3'b101) begin
            // |a| of the most negative operand is 2^(N-1), so N multiplier bits suffice
            acc    <= '0;
            mcand  <= {{(N-1){1'b0}}, abs_a};
            mplier <= abs_a;
            cnt    <= CNT_N;
          end else if (iterative) begin
            shreg <= bus.a;
            cnt   <= shamt[CW-1:0];
          end else begin
            bus.result   <= sc_res;
            bus.sign     <= (bus.op == 3'b011) ? 1'b0 : sc_res[N-1];
            bus.overflow <= sc_ovf;
            bus.status   <= sc_status;
          end
        end
        EXEC: begin
          cnt <= cnt - 1'b1;
          if (op_r == 3'b101) begin
            acc    <= sq_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (last) begin
              bus.result   <= sq_next[N-1:0];
              bus.sign     <= sq_next[N-1];
              bus.overflow <= (sq_next > SQ_MAX);
              bus.status   <= 1'b0;
            end
          end else begin
            shreg <= asr_next;
            if (last) begin
              bus.result   <= asr_next;
              bus.sign     <= asr_next[N-1];
              bus.overflow <= 1'b0;
              bus.status   <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit (N=5): hand-computed results, flags and latencies,
// backpressure hold and reset abort in the middle of a SQUARE.
module tb_alu_seq_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  int   lat;

  alu_seq_if #(.N(5)) bus ();
  alu_seq_unit #(.N(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic send(input logic [4:0] ta, input logic [4:0] tb_v, input logic [2:0] top);
    @(negedge clk);
    bus.a = ta; bus.b = tb_v; bus.op = top; bus.in_valid = 1'b1;
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.a = ~ta; bus.b = ~tb_v; bus.op = ~top;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (bus.out_valid) break;
    end
  endtask

  task automatic run(input string tag, input logic [4:0] ta, input logic [4:0] tb_v,
                     input logic [2:0] top, input logic [4:0] er, input logic [2:0] eflags,
                     input int elat);
    int n;
    send(ta, tb_v, top);
    wait_resp(n);
    chk({tag, "_lat"}, 32'(n), 32'(elat));
    chk({tag, "_result"}, 32'(bus.result), 32'(er));
    chk({tag, "_sign_ovf_status"}, 32'({bus.sign, bus.overflow, bus.status}), 32'(eflags));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.op = '0;
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_result", 32'({bus.result, bus.sign, bus.overflow, bus.status}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // flags are {sign, overflow, status}
    run("add_neg",   5'b11011, 5'b00011, 3'b000, 5'b11110, 3'b100, 1);
    run("add_ovf",   5'b01111, 5'b00001, 3'b000, 5'b10000, 3'b110, 1);
    run("sub",       5'b00111, 5'b00011, 3'b001, 5'b00100, 3'b000, 1);
    run("sub_ovf",   5'b10000, 5'b00001, 3'b001, 5'b01111, 3'b010, 1);
    run("abs_min",   5'b10000, 5'b00000, 3'b110, 5'b10000, 3'b110, 1);
    run("abs_neg",   5'b11101, 5'b00000, 3'b110, 5'b00011, 3'b000, 1);
    run("cmp_true",  5'b11100, 5'b00001, 3'b011, 5'b00001, 3'b001, 1);
    run("cmp_false", 5'b00011, 5'b11111, 3'b011, 5'b00000, 3'b000, 1);
    run("avg",       5'b11100, 5'b00010, 3'b100, 5'b11111, 3'b100, 1);
    run("avg_max",   5'b01111, 5'b01111, 3'b100, 5'b01111, 3'b000, 1);
    run("max",       5'b11101, 5'b00010, 3'b010, 5'b00010, 3'b000, 1);
    run("sq_neg3",   5'b11101, 5'b00000, 3'b101, 5'b01001, 3'b000, 6);
    run("sq_6",      5'b00110, 5'b00000, 3'b101, 5'b00100, 3'b010, 6);
    run("sq_min",    5'b10000, 5'b00000, 3'b101, 5'b00000, 3'b010, 6);
    run("asr1",      5'b11100, 5'b00001, 3'b111, 5'b11110, 3'b100, 2);
    run("asr3",      5'b01010, 5'b00011, 3'b111, 5'b00001, 3'b000, 4);
    run("asr_clamp", 5'b11100, 5'b01001, 3'b111, 5'b11111, 3'b100, 5);
    run("asr0",      5'b01010, 5'b00000, 3'b111, 5'b01010, 3'b000, 1);

    // backpressure: response held, extra requests ignored
    send(5'b00001, 5'b00010, 3'b000);
    wait_resp(lat);
    chk("bp_lat", 32'(lat), 32'd1);
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1; bus.a = 5'b01111; bus.op = 3'b101;
      @(negedge clk);
      chk("bp_result", 32'({bus.result, bus.sign, bus.overflow, bus.status}), 32'({5'b00011, 3'b000}));
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    chk("bp_no_ghost", 32'(bus.out_valid), 32'd0);

    // reset while SQUARE iterates
    send(5'b00110, 5'b00000, 3'b101);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_result", 32'(bus.result), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 chk("midrst_in_ready_hold", 32'(bus.in_ready), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("midrst_no_resp", 32'(bus.out_valid), 32'd0);
    end
    run("sq_after_rst", 5'b11101, 5'b00000, 3'b101, 5'b01001, 3'b000, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
